// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
// Shared definitions for the iterative multiplier sequencer:
//   DEFAULT_DATA_W - default operand/result width
//   DEFAULT_CNT_W  - width of the step counter for the default width
//   seq_state_t    - controller state encoding (2'd3 is unused and
//                    recovers to IDLE)
package mul_seq_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if
// Handshake between the EX stage and the multiplier sequencer.
//   enable    - global run enable (low freezes everything)
//   start     - EX holds a valid MUL (level, held while stalled)
//   kill      - flush of the EX instruction
//   operand_a - multiplicand
//   operand_b - multiplier
//   stall     - hold IF/IF_ID/ID_EX, bubble into EX_MEM
//   done      - result valid this cycle
//   result    - low DATA_W bits of the product
//   busy      - sequencer not idle
// Modports: master = pipeline side, slave = sequencer side.
interface mul_sequencer_if
    import mul_seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              enable;
    logic              start;
    logic              kill;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output enable, start, kill, operand_a, operand_b,
        input  stall, done, result, busy
    );

    modport slave (
        input  enable, start, kill, operand_a, operand_b,
        output stall, done, result, busy
    );

endinterface

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp
// Radix-2 shift-add datapath: accumulator, shifting multiplicand and
// multiplier, and a step counter. Driven purely by strobes from the
// controller, so it holds whenever no strobe is given.
//   clk, arst_n          - clock, async active-low reset
//   load                 - capture operands, clear acc and counter
//   step                 - perform one shift-add iteration
//   clear                - discard the accumulator (aborted operation)
//   operand_a, operand_b - multiplicand / multiplier
//   acc                  - running product
//   last_step            - the current step is the final one
module mul_shift_add_dp
    import mul_seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic              step,
    input  logic              clear,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] acc,
    output logic              last_step
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;

    // Early exit once no set multiplier bits remain after this shift;
    // the counter bound covers an operand_b whose MSB is set.
    assign last_step = ((mplier >> 1) == '0) || (cnt == CNT_W'(DATA_W - 1));

    // Clear beats load beats step; with no strobe every register holds.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= operand_a;
            mplier <= operand_b;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer
// Controller for the multi-cycle iterative multiplier in EX. Stalls the
// pipeline while iterating and drops stall for exactly the one DONE cycle
// in which the result is valid.
//   clk    - main clock
//   arst_n - asynchronous active-low reset
//   bus    - mul_sequencer_if slave port (see interface header)
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk,
    input  logic                  arst_n,
    mul_sequencer_if.slave        bus
);

    localparam int CNT_W = $clog2(DATA_W);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              load;
    logic              step;
    logic              clear;
    logic [DATA_W-1:0] acc;
    logic              last_step;

    mul_shift_add_dp #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dp (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (load),
        .step      (step),
        .clear     (clear),
        .operand_a (bus.operand_a),
        .operand_b (bus.operand_b),
        .acc       (acc),
        .last_step (last_step)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With enable low no strobe fires and the state holds. Kill wins over
    // everything, including the BUSY->DONE exit. Start is ignored in DONE
    // because the instruction that produced the result is still in EX.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        clear      = 1'b0;
        if (bus.enable) begin
            if (bus.kill) begin
                state_next = IDLE;
                clear      = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            load       = 1'b1;
                            state_next = BUSY;
                        end
                    end
                    BUSY: begin
                        step = 1'b1;
                        if (last_step) begin
                            state_next = DONE;
                        end
                    end
                    DONE: begin
                        state_next = IDLE;
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    // Stall depends only on start/kill/state so there is no path from the
    // operands to any output.
    assign bus.stall  = ((state == IDLE) && bus.start && !bus.kill) || (state == BUSY);
    assign bus.done   = (state == DONE);
    assign bus.result = (state == DONE) ? acc : '0;
    assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
// Directed self-checking bench for mul_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_mul_sequencer;

    logic clk;
    logic arst_n;
    int   n_checks;
    int   n_fail;

    mul_sequencer_if #(.DATA_W(64)) bus ();

    mul_sequencer #(.DATA_W(64)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one MUL from an IDLE cycle (called at rising edge + 1) and
    // measures it. Leaves start high and returns in the cycle after DONE.
    task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                          output int busy_cycles, output logic [63:0] res,
                          output logic stall0, output logic busy0,
                          output logic stall_done, output int bad_busy,
                          output logic timed_out);
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        @(negedge clk);
        stall0 = bus.stall;
        busy0  = bus.busy;
        @(posedge clk);
        busy_cycles = 0;
        bad_busy    = 0;
        timed_out   = 1'b1;
        res         = '0;
        stall_done  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                res        = bus.result;
                stall_done = bus.stall;
                timed_out  = 1'b0;
                break;
            end
            if (bus.busy && bus.stall && (bus.result == '0)) busy_cycles++;
            else bad_busy++;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.result !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int n, bad; logic [63:0] r; logic s0, b0, sd, to;
        do_mul(64'd7, 64'd6, n, r, s0, b0, sd, bad, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
        n_checks++; if (s0 !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_stall_cycle0: got %b expected 1", s0); end
        n_checks++; if (b0 !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_cycle0: got %b expected 0", b0); end
        n_checks++; if (n != 3) begin n_fail++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 3", n); end
        n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL basic_busy_outputs: got %0d bad cycles expected 0", bad); end
        n_checks++; if (r !== 64'd42) begin n_fail++; $display("[TB] FAIL basic_result: got %0d expected 42", r); end
        n_checks++; if (sd !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_stall_done: got %b expected 0", sd); end
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.stall, bus.done, bus.busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL basic_idle_after: got %b expected 000", {bus.stall, bus.done, bus.busy}); end
        @(posedge clk); #1;
    endtask

    task automatic test_patterns();
        int n, bad; logic [63:0] r; logic s0, b0, sd, to;
        do_mul(64'h1234, 64'h0, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 1) begin n_fail++; $display("[TB] FAIL zero_busy_cycles: got %0d expected 1", n); end
        n_checks++; if (r !== 64'h0) begin n_fail++; $display("[TB] FAIL zero_result: got %h expected 0", r); end
        bus.start = 1'b0; @(posedge clk); #1;
        do_mul(64'd3, 64'h8000_0000_0000_0000, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 64) begin n_fail++; $display("[TB] FAIL msb_busy_cycles: got %0d expected 64", n); end
        n_checks++; if (r !== 64'h8000_0000_0000_0000) begin n_fail++; $display("[TB] FAIL msb_result: got %h expected 8000000000000000", r); end
        bus.start = 1'b0; @(posedge clk); #1;
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n + 1 != 65) begin n_fail++; $display("[TB] FAIL ones_stall_cycles: got %0d expected 65", n + 1); end
        n_checks++; if (r !== 64'h1) begin n_fail++; $display("[TB] FAIL ones_result: got %h expected 1", r); end
        n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL ones_busy_outputs: got %0d bad cycles expected 0", bad); end
        bus.start = 1'b0; @(posedge clk); #1;
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 2) begin n_fail++; $display("[TB] FAIL neg2_busy_cycles: got %0d expected 2", n); end
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("[TB] FAIL neg2_result: got %h expected fffffffffffffffe", r); end
        bus.start = 1'b0; @(posedge clk); #1;
        do_mul(64'h1_0000_0000, 64'h1_0000_0000, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 33) begin n_fail++; $display("[TB] FAIL ovf_busy_cycles: got %0d expected 33", n); end
        n_checks++; if (r !== 64'h0) begin n_fail++; $display("[TB] FAIL ovf_result: got %h expected 0", r); end
        bus.start = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n, bad; logic [63:0] r; logic s0, b0, sd, to;
        do_mul(64'd5, 64'd5, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 3) begin n_fail++; $display("[TB] FAIL b2b_first_cycles: got %0d expected 3", n); end
        n_checks++; if (r !== 64'd25) begin n_fail++; $display("[TB] FAIL b2b_first_result: got %0d expected 25", r); end
        do_mul(64'd9, 64'd2, n, r, s0, b0, sd, bad, to);
        n_checks++; if ({s0, b0} !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_gap_cycle: got stall,busy=%b expected 10", {s0, b0}); end
        n_checks++; if (n != 2) begin n_fail++; $display("[TB] FAIL b2b_second_cycles: got %0d expected 2", n); end
        n_checks++; if (r !== 64'd18) begin n_fail++; $display("[TB] FAIL b2b_second_result: got %0d expected 18", r); end
        bus.start = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_kill();
        int n, bad, pulses; logic [63:0] r; logic s0, b0, sd, to;
        bus.operand_a = 64'hFF; bus.operand_b = 64'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.kill = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL kill_busy_stall: got %b expected 1", bus.stall); end
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.stall, bus.done, bus.busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL kill_to_idle: got %b expected 000", {bus.stall, bus.done, bus.busy}); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL kill_no_done: got %0d pulses expected 0", pulses); end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.kill = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL kill_idle_stall: got %b expected 0", bus.stall); end
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL kill_idle_busy: got %b expected 0", bus.busy); end
        bus.kill = 1'b0;
        bus.operand_a = 64'd7; bus.operand_b = 64'd1;
        @(posedge clk); #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL kill_over_exit: got done,busy=%b expected 00", {bus.done, bus.busy}); end
        @(posedge clk); #1;
        do_mul(64'hFF, 64'hFF, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 8) begin n_fail++; $display("[TB] FAIL kill_fresh_cycles: got %0d expected 8", n); end
        n_checks++; if (r !== 64'hFE01) begin n_fail++; $display("[TB] FAIL kill_fresh_result: got %h expected fe01", r); end
        bus.start = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_enable();
        int en_busy, frozen, bad;
        logic got_done;
        logic [63:0] r;
        bus.operand_a = 64'd7; bus.operand_b = 64'd6; bus.start = 1'b1;
        @(posedge clk); #1;
        en_busy = 0; frozen = 0; bad = 0; got_done = 1'b0; r = '0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            bus.enable = !(cyc >= 2 && cyc <= 6);
            @(negedge clk);
            if (bus.done) begin
                got_done = 1'b1;
                r = bus.result;
                break;
            end
            if (bus.busy && bus.stall) begin
                if (bus.enable) en_busy++;
                else frozen++;
            end else begin
                bad++;
            end
            @(posedge clk); #1;
        end
        bus.enable = 1'b1;
        n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL enable_done_seen: got %b expected 1", got_done); end
        n_checks++; if (en_busy != 3) begin n_fail++; $display("[TB] FAIL enable_busy_cycles: got %0d expected 3", en_busy); end
        n_checks++; if (frozen != 5 || bad != 0) begin n_fail++; $display("[TB] FAIL enable_frozen: got %0d frozen %0d bad expected 5 and 0", frozen, bad); end
        n_checks++; if (r !== 64'd42) begin n_fail++; $display("[TB] FAIL enable_result: got %0d expected 42", r); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int n, bad; logic [63:0] r; logic s0, b0, sd, to;
        bus.operand_a = 64'hFF; bus.operand_b = 64'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        n_checks++; if ({bus.stall, bus.done, bus.busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL arst_outputs: got %b expected 000", {bus.stall, bus.done, bus.busy}); end
        n_checks++; if (bus.result !== 64'h0) begin n_fail++; $display("[TB] FAIL arst_result: got %h expected 0", bus.result); end
        #3;
        arst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_stays_idle: got %b expected 0", bus.busy); end
        do_mul(64'h10, 64'h10, n, r, s0, b0, sd, bad, to);
        n_checks++; if (n != 5) begin n_fail++; $display("[TB] FAIL arst_fresh_cycles: got %0d expected 5", n); end
        n_checks++; if (r !== 64'h100) begin n_fail++; $display("[TB] FAIL arst_fresh_result: got %h expected 100", r); end
        bus.start = 1'b0; @(posedge clk); #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        arst_n        = 1'b0;
        bus.enable    = 1'b1;
        bus.start     = 1'b0;
        bus.kill      = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        @(posedge clk);
        $display("[TB] starting mul_sequencer tests");
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_kill();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
